// File: rtl/data_bus_controller_if.sv
// Load/store bus bundle: execute-stage request, slave-side bus, read data and writeback result.
interface data_bus_controller_if;
    // Request from the execute stage
    logic        req_valid;
    logic        req_store;
    logic [1:0]  req_width;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Bus towards the slaves
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic [1:0]  data_bus_reqw;
    logic        data_bus_reqs;
    logic        sel_flash;
    logic        sel_ram;
    logic        sel_io;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    // Already-formatted read data from each slave
    logic [31:0] flash_rdata;
    logic [31:0] ram_rdata;
    logic [31:0] io_rdata;

    // Pipeline-facing status and load result
    logic        stall_lw;
    logic        load_valid;
    logic [31:0] load_result;
    logic        fault;
    logic [1:0]  fault_cause;

    modport master (
        input  req_valid, req_store, req_width, req_signed, req_addr, req_wdata,
        input  flash_rdata, ram_rdata, io_rdata,
        output data_bus_addr, data_bus_mode, data_bus_reqw, data_bus_reqs,
        output sel_flash, sel_ram, sel_io, wdata, wstrb,
        output stall_lw, load_valid, load_result, fault, fault_cause
    );

    modport slave (
        output req_valid, req_store, req_width, req_signed, req_addr, req_wdata,
        output flash_rdata, ram_rdata, io_rdata,
        input  data_bus_addr, data_bus_mode, data_bus_reqw, data_bus_reqs,
        input  sel_flash, sel_ram, sel_io, wdata, wstrb,
        input  stall_lw, load_valid, load_result, fault, fault_cause
    );
endinterface

// File: rtl/data_bus_controller.sv
// Load/store front end: address decode, alignment/rights check, two-cycle load sequencing
// and flash-port sharing via stall_lw.
module data_bus_controller #(
    parameter int unsigned FLASH_WORDS = 3072,
    parameter logic [31:0] RAM_BASE    = 32'h0001_0000,
    parameter int unsigned RAM_WORDS   = 1024,
    parameter logic [31:0] IO_BASE     = 32'h0002_0000
) (
    input logic                   clk,
    input logic                   reset,
    data_bus_controller_if.master dbus
);

    localparam logic [31:0] FlashBytes = 32'(4 * FLASH_WORDS);
    localparam logic [31:0] RamBytes   = 32'(4 * RAM_WORDS);
    localparam logic [31:0] IoBytes    = 32'h0000_1000;

    localparam logic [1:0] ModeIdle  = 2'b00;
    localparam logic [1:0] ModeRead  = 2'b01;
    localparam logic [1:0] ModeWrite = 2'b10;

    localparam logic [1:0] CauseMisaligned = 2'b01;
    localparam logic [1:0] CauseUnmapped   = 2'b10;
    localparam logic [1:0] CauseFlashStore = 2'b11;

    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  width_q;
    logic        signed_q;
    logic [2:0]  sel_q;      // {io, ram, flash}
    logic        load_start;

    logic        misaligned;
    logic        in_flash;
    logic        in_ram;
    logic        in_io;
    logic [2:0]  hit;

    logic [31:0] bus_addr;
    logic [1:0]  bus_mode;
    logic [1:0]  bus_reqw;
    logic        bus_reqs;
    logic [2:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_result;
    logic        flt;
    logic [1:0]  flt_cause;

    // Address decode and alignment check on the incoming request
    always_comb begin
        // Reserved width code 11 is rejected together with misaligned accesses
        misaligned = ((dbus.req_width == 2'b00) && (dbus.req_addr[1:0] != 2'b00)) ||
                     ((dbus.req_width == 2'b01) && (dbus.req_addr[1:0] == 2'b11)) ||
                     (dbus.req_width == 2'b11);
        in_flash   = dbus.req_addr < FlashBytes;
        in_ram     = (dbus.req_addr >= RAM_BASE) && ((dbus.req_addr - RAM_BASE) < RamBytes);
        in_io      = (dbus.req_addr >= IO_BASE) && ((dbus.req_addr - IO_BASE) < IoBytes);
        hit        = {in_io, in_ram, in_flash};
    end

    // Next-state and bus outputs; reset forces every output low
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        bus_addr   = 32'h0;
        bus_mode   = ModeIdle;
        bus_reqw   = 2'b00;
        bus_reqs   = 1'b0;
        bus_sel    = 3'b000;
        bus_wdata  = 32'h0;
        bus_wstrb  = 4'b0000;
        stall      = 1'b0;
        ld_valid   = 1'b0;
        ld_result  = 32'h0;
        flt        = 1'b0;
        flt_cause  = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (dbus.req_valid) begin
                    if (misaligned) begin
                        flt       = 1'b1;
                        flt_cause = CauseMisaligned;
                    end else if (hit == 3'b000) begin
                        flt       = 1'b1;
                        flt_cause = CauseUnmapped;
                    end else if (dbus.req_store && in_flash) begin
                        flt       = 1'b1;
                        flt_cause = CauseFlashStore;
                    end else begin
                        bus_addr = dbus.req_addr;
                        bus_reqw = dbus.req_width;
                        bus_reqs = dbus.req_signed;
                        bus_sel  = hit;
                        if (dbus.req_store) begin
                            bus_mode  = ModeWrite;
                            bus_wdata = dbus.req_wdata << {dbus.req_addr[1:0], 3'b000};
                            unique case (dbus.req_width)
                                2'b00:   bus_wstrb = 4'b1111;
                                2'b01:   bus_wstrb = 4'b0011 << dbus.req_addr[1:0];
                                default: bus_wstrb = 4'b0001 << dbus.req_addr[1:0];
                            endcase
                        end else begin
                            bus_mode   = ModeRead;
                            stall      = 1'b1;
                            load_start = 1'b1;
                            state_d    = StLoadWait;
                        end
                    end
                end
            end
            StLoadWait: begin
                // req_valid is ignored here: the stalled pipeline still shows the same load
                bus_addr = addr_q;
                bus_mode = ModeRead;
                bus_reqw = width_q;
                bus_reqs = signed_q;
                bus_sel  = sel_q;
                ld_valid = 1'b1;
                unique case (sel_q)
                    3'b001:  ld_result = dbus.flash_rdata;
                    3'b010:  ld_result = dbus.ram_rdata;
                    3'b100:  ld_result = dbus.io_rdata;
                    default: ld_result = 32'h0;
                endcase
                state_d = StIdle;
            end
        endcase

        if (!reset) begin
            state_d    = StIdle;
            load_start = 1'b0;
            bus_addr   = 32'h0;
            bus_mode   = ModeIdle;
            bus_reqw   = 2'b00;
            bus_reqs   = 1'b0;
            bus_sel    = 3'b000;
            bus_wdata  = 32'h0;
            bus_wstrb  = 4'b0000;
            stall      = 1'b0;
            ld_valid   = 1'b0;
            ld_result  = 32'h0;
            flt        = 1'b0;
            flt_cause  = 2'b00;
        end
    end

    // State register and the load context captured on the stall cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            width_q  <= 2'b00;
            signed_q <= 1'b0;
            sel_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            if (load_start) begin
                addr_q   <= dbus.req_addr;
                width_q  <= dbus.req_width;
                signed_q <= dbus.req_signed;
                sel_q    <= hit;
            end
        end
    end

    assign dbus.data_bus_addr = bus_addr;
    assign dbus.data_bus_mode = bus_mode;
    assign dbus.data_bus_reqw = bus_reqw;
    assign dbus.data_bus_reqs = bus_reqs;
    assign dbus.sel_flash     = bus_sel[0];
    assign dbus.sel_ram       = bus_sel[1];
    assign dbus.sel_io        = bus_sel[2];
    assign dbus.wdata         = bus_wdata;
    assign dbus.wstrb         = bus_wstrb;
    assign dbus.stall_lw      = stall;
    assign dbus.load_valid    = ld_valid;
    assign dbus.load_result   = ld_result;
    assign dbus.fault         = flt;
    assign dbus.fault_cause   = flt_cause;

endmodule

// File: tb/tb_data_bus_controller.sv
// Scoreboard bench for data_bus_controller: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares whenever the DUT drives anything non-idle.
module tb_data_bus_controller;

    typedef struct packed {
        logic        stall;
        logic        lv;
        logic [31:0] res;
        logic        flt;
        logic [1:0]  cause;
        logic [1:0]  mode;
        logic [2:0]  sel;     // {io, ram, flash}
        logic [1:0]  reqw;
        logic        reqs;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] addr;
    } snap_t;

    typedef struct {
        string name;
        snap_t s;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    data_bus_controller_if bus_if ();

    data_bus_controller dut (
        .clk   (clk),
        .reset (reset),
        .dbus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t mk(logic stall, logic lv, logic [31:0] res, logic flt,
                                 logic [1:0] cause, logic [1:0] mode, logic [2:0] sel,
                                 logic [1:0] reqw, logic reqs, logic [3:0] wstrb,
                                 logic [31:0] wdata, logic [31:0] addr);
        snap_t s;
        s.stall = stall; s.lv = lv; s.res = res; s.flt = flt; s.cause = cause;
        s.mode = mode; s.sel = sel; s.reqw = reqw; s.reqs = reqs; s.wstrb = wstrb;
        s.wdata = wdata; s.addr = addr;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        return mk(bus_if.stall_lw, bus_if.load_valid, bus_if.load_result, bus_if.fault,
                  bus_if.fault_cause, bus_if.data_bus_mode,
                  {bus_if.sel_io, bus_if.sel_ram, bus_if.sel_flash},
                  bus_if.data_bus_reqw, bus_if.data_bus_reqs, bus_if.wstrb, bus_if.wdata,
                  bus_if.data_bus_addr);
    endfunction

    function automatic snap_t fault_snap(logic [1:0] cause);
        return mk(1'b0, 1'b0, 32'h0, 1'b1, cause, 2'b00, 3'b000, 2'b00, 1'b0, 4'h0, 32'h0,
                  32'h0);
    endfunction

    task automatic report(string name, snap_t act, snap_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got stall=%b lv=%b res=%h flt=%b cause=%b mode=%b sel=%b reqw=%b reqs=%b wstrb=%b wdata=%h addr=%h | want stall=%b lv=%b res=%h flt=%b cause=%b mode=%b sel=%b reqw=%b reqs=%b wstrb=%b wdata=%h addr=%h",
                     name, act.stall, act.lv, act.res, act.flt, act.cause, act.mode,
                     act.sel, act.reqw, act.reqs, act.wstrb, act.wdata, act.addr,
                     req.stall, req.lv, req.res, req.flt, req.cause, req.mode, req.sel,
                     req.reqw, req.reqs, req.wstrb, req.wdata, req.addr);
        end
    endtask

    task automatic push(string name, snap_t s);
        exp_t e;
        e.name = name;
        e.s    = s;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(logic store, logic [1:0] width, logic sgn, logic [31:0] addr,
                       logic [31:0] wd);
        bus_if.req_valid  = 1'b1;
        bus_if.req_store  = store;
        bus_if.req_width  = width;
        bus_if.req_signed = sgn;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wd;
    endtask

    task automatic idle();
        bus_if.req_valid  = 1'b0;
        bus_if.req_store  = 1'b0;
        bus_if.req_width  = 2'b00;
        bus_if.req_signed = 1'b0;
        bus_if.req_addr   = 32'h0;
        bus_if.req_wdata  = 32'h0;
    endtask

    // Monitor: any non-idle output must match the next queued expectation
    always @(negedge clk) begin
        snap_t cur;
        exp_t  e;
        cur = dut_snap();
        if (cur != '0) begin
            if (exp_q.size() == 0) begin
                report("unexpected_output", cur, '0);
            end else begin
                e = exp_q.pop_front();
                report(e.name, cur, e.s);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle();
        bus_if.flash_rdata = 32'hDEAD_BEEF;
        bus_if.ram_rdata   = 32'hFFFF_FF80;
        bus_if.io_rdata    = 32'h0BAD_F00D;

        repeat (2) @(negedge clk);
        report("reset_state", dut_snap(), '0);
        step();
        reset = 1'b1;
        step();

        // Word load from flash
        req(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
        push("ld_flash_T", mk(1, 0, 32'h0, 0, 2'b00, 2'b01, 3'b001, 2'b00, 0, 4'h0, 32'h0,
                              32'h10));
        step();
        push("ld_flash_T1", mk(0, 1, 32'hDEAD_BEEF, 0, 2'b00, 2'b01, 3'b001, 2'b00, 0, 4'h0,
                               32'h0, 32'h10));
        step();
        idle();
        step();

        // Signed byte load from RAM
        req(1'b0, 2'b10, 1'b1, 32'h0001_0003, 32'h0);
        push("ld_ram_T", mk(1, 0, 32'h0, 0, 2'b00, 2'b01, 3'b010, 2'b10, 1, 4'h0, 32'h0,
                            32'h0001_0003));
        step();
        push("ld_ram_T1", mk(0, 1, 32'hFFFF_FF80, 0, 2'b00, 2'b01, 3'b010, 2'b10, 1, 4'h0,
                             32'h0, 32'h0001_0003));
        step();
        idle();
        step();

        // Stores: half to RAM, byte to I/O, word to RAM
        req(1'b1, 2'b01, 1'b0, 32'h0001_0002, 32'h0000_1234);
        push("st_half_ram", mk(0, 0, 32'h0, 0, 2'b00, 2'b10, 3'b010, 2'b01, 0, 4'b1100,
                               32'h1234_0000, 32'h0001_0002));
        step();
        req(1'b1, 2'b10, 1'b0, 32'h0002_0001, 32'h0000_00AB);
        push("st_byte_io", mk(0, 0, 32'h0, 0, 2'b00, 2'b10, 3'b100, 2'b10, 0, 4'b0010,
                              32'h0000_AB00, 32'h0002_0001));
        step();
        req(1'b1, 2'b00, 1'b0, 32'h0001_0004, 32'hCAFE_F00D);
        push("st_word_ram", mk(0, 0, 32'h0, 0, 2'b00, 2'b10, 3'b010, 2'b00, 0, 4'b1111,
                               32'hCAFE_F00D, 32'h0001_0004));
        step();

        // Faults: never stall, never leave idle
        req(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0);
        push("flt_misaligned_word", fault_snap(2'b01));
        step();
        req(1'b0, 2'b00, 1'b0, 32'h0003_0000, 32'h0);
        push("flt_unmapped", fault_snap(2'b10));
        step();
        req(1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h1111_1111);
        push("flt_store_flash", fault_snap(2'b11));
        step();
        req(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0);
        push("flt_misaligned_half", fault_snap(2'b01));
        step();
        req(1'b0, 2'b00, 1'b0, 32'h0003_0001, 32'h0);
        push("flt_priority", fault_snap(2'b01));
        step();
        req(1'b0, 2'b00, 1'b0, 32'h0000_3000, 32'h0);
        push("flt_past_flash", fault_snap(2'b10));
        step();
        idle();
        step();

        // Word load at the top of the I/O page
        req(1'b0, 2'b00, 1'b0, 32'h0002_0FFC, 32'h0);
        push("ld_io_T", mk(1, 0, 32'h0, 0, 2'b00, 2'b01, 3'b100, 2'b00, 0, 4'h0, 32'h0,
                           32'h0002_0FFC));
        step();
        push("ld_io_T1", mk(0, 1, 32'h0BAD_F00D, 0, 2'b00, 2'b01, 3'b100, 2'b00, 0, 4'h0,
                            32'h0, 32'h0002_0FFC));
        step();
        idle();
        step();

        // Back-to-back loads with req_valid held: stall 1,0,1,0
        bus_if.io_rdata = 32'h5555_AAAA;
        req(1'b0, 2'b00, 1'b0, 32'h0002_0000, 32'h0);
        for (int i = 0; i < 2; i++) begin
            push("b2b_stall", mk(1, 0, 32'h0, 0, 2'b00, 2'b01, 3'b100, 2'b00, 0, 4'h0, 32'h0,
                                 32'h0002_0000));
            step();
            push("b2b_valid", mk(0, 1, 32'h5555_AAAA, 0, 2'b00, 2'b01, 3'b100, 2'b00, 0,
                                 4'h0, 32'h0, 32'h0002_0000));
            step();
        end
        idle();
        step();

        // Reset during the completion cycle: no load_valid, then a normal load
        req(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
        push("rst_ld_T", mk(1, 0, 32'h0, 0, 2'b00, 2'b01, 3'b001, 2'b00, 0, 4'h0, 32'h0,
                            32'h10));
        step();
        reset = 1'b0;
        @(negedge clk);
        report("rst_in_wait_zero", dut_snap(), '0);
        step();
        reset = 1'b1;
        push("after_rst_T", mk(1, 0, 32'h0, 0, 2'b00, 2'b01, 3'b001, 2'b00, 0, 4'h0, 32'h0,
                               32'h10));
        step();
        push("after_rst_T1", mk(0, 1, 32'hDEAD_BEEF, 0, 2'b00, 2'b01, 3'b001, 2'b00, 0, 4'h0,
                                32'h0, 32'h10));
        step();
        idle();
        repeat (3) step();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0",
                     exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_controller.md
# data_bus_controller

Load/store front end between the execute stage and the data-bus slaves: program flash, data RAM and the I/O page. It decodes the effective address into one slave select and checks alignment and access rights. It sequences each load as a two-cycle transaction (stall cycle, then completion cycle) and returns the selected slave's already width-formatted read data to writeback. It generates `stall_lw`, which the pipeline and program flash use to share the flash read port with instruction fetch.

## Interface
Parameters:
- `FLASH_WORDS`, 3072: flash size in words; flash region is 0x0000_0000 to 4*FLASH_WORDS-1.
- `RAM_BASE`, 32'h0001_0000: RAM base address, 64 KiB aligned.
- `RAM_WORDS`, 1024: RAM size in words.
- `IO_BASE`, 32'h0002_0000: base of the 4 KiB I/O page.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; one clock, no other clock domains.
- `req_valid`  in  1  execute stage presents a memory operation.
- `req_store`  in  1  1 = store, 0 = load.
- `req_width`  in  2  00 word, 01 half-word, 10 byte.
- `req_signed`  in  1  sign-extend a sub-word load.
- `req_addr`  in  32  effective byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `data_bus_addr`  out  32  address to the slaves.
- `data_bus_mode`  out  2  00 idle, 01 read, 10 write.
- `data_bus_reqw`  out  2  copy of the width code.
- `data_bus_reqs`  out  1  copy of the signed flag.
- `sel_flash`, `sel_ram`, `sel_io`  out  1 each  one-hot slave selects.
- `wdata`  out  32  store data shifted into byte lanes.
- `wstrb`  out  4  byte-lane write enables.
- `flash_rdata`, `ram_rdata`, `io_rdata`  in  32 each  formatted read data from each slave.
- `stall_lw`  out  1  first (stall) cycle of a load.
- `load_valid`  out  1  load result valid this cycle.
- `load_result`  out  32  load data to writeback.
- `fault`  out  1  the access was rejected.
- `fault_cause`  out  2  01 misaligned, 10 unmapped, 11 store to flash.

## Operation
- FSM states: IDLE and LOAD_WAIT. Reset value is IDLE, with every output 0.
- **Decode in IDLE, combinational on `req_*`:**
  - Misaligned if a word access has addr[1:0]≠0, or a half-word access has addr[1:0]=11.
  - Unmapped if the address falls in no region.
  - Store to flash is a fault.
  - Fault priority: misaligned > unmapped > store-to-flash.
- **Faulting request:** `fault`=1 and `fault_cause` is set, both in the same cycle. All selects are 0, mode is 00 and `stall_lw`=0. The FSM stays in IDLE.
- **Store:**
  - Single cycle: mode=10 and exactly one select is high.
  - `wstrb`: byte gives 0001<<addr[1:0]; half-word gives 0011<<addr[1:0]; word gives 1111.
  - `wdata` = `req_wdata` << (8*addr[1:0]).
- **Load:**
  - In IDLE: mode=01, select driven, `stall_lw`=1. Next state is LOAD_WAIT; the controller registers addr, width, signed and the select.
  - In LOAD_WAIT: the bus is driven from the registered copies with mode=01 and `stall_lw`=0. `load_valid`=1 and `load_result` is the registered-select mux of `*_rdata`. Next state is IDLE.
  - `req_valid` is ignored in LOAD_WAIT, because the pipeline still presents the same load.
- When not in a load or store, `wstrb`=0, `wdata`=0 and `load_result`=0.

## Timing
- Store latency is 0 cycles: the write happens at the edge ending the request cycle.
- **Load at request cycle T:**
  - Cycle T: `stall_lw`=1 and the pipeline holds.
  - Edge T→T+1: the slave registers its read.
  - Cycle T+1: `load_valid`=1 and `load_result` is valid.
  - A new request is accepted no earlier than T+2.
- Back-to-back loads toggle `stall_lw` 1,0,1,0 and never assert it in LOAD_WAIT.
- Faults never stall and never leave IDLE.
- If `reset` is asserted during LOAD_WAIT, the FSM returns to IDLE immediately and all outputs go to 0. No `load_valid` pulse is produced.

## Test plan
- Load word at 0x0000_0010 (flash holds 0xDEADBEEF formatted):
  - Cycle T: `stall_lw`=1, `sel_flash`=1, mode=01.
  - Cycle T+1: `load_valid`=1, `load_result`=0xDEADBEEF, `stall_lw`=0.
- Signed byte load at RAM_BASE+3 with `ram_rdata`=0xFFFFFF80: `sel_ram`=1 in both cycles; `load_result`=0xFFFFFF80 at T+1.
- Half-word store of 0x1234 at RAM_BASE+2: mode=10, `wstrb`=1100, `wdata`=0x1234_0000, one cycle, no stall.
- Faults, each with no select and no stall:
  - Word load at 0x0000_0006 gives `fault_cause`=01.
  - Load at 0x0003_0000 gives 10.
  - Store at 0x0000_0100 gives 11.
- Two consecutive loads with `req_valid` held high: exactly two `load_valid` pulses, at T+1 and T+3.
- Reset pulse in T+1 of a load: outputs 0 in that cycle and no `load_valid`. The next load behaves normally.
